// File: rtl/computer_pkg.sv
// Shared definitions for the FPGAComputer boot path: loader FSM states, data width
// and the default EEPROM location of the program image.
package computer_pkg;

    localparam int DATA_W = 8;
    localparam logic [DATA_W-1:0] EE_BASE_DEFAULT = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT      = 3'd2,
        S_WRITE     = 3'd3,
        S_CSUM_REQ  = 3'd4,
        S_CSUM_WAIT = 3'd5,
        S_FIN       = 3'd6,
        S_FAIL      = 3'd7
    } loader_state_t;

    // States from which a GO pulse starts a fresh load.
    function automatic logic is_quiescent(loader_state_t s);
        return (s == S_IDLE) || (s == S_FIN) || (s == S_FAIL);
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Loadable down-counter that bounds each EEPROM handshake wait; expired is high
// once the loaded budget has been counted down to zero.
module loader_timeout #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/eeprom_loader.sv
// Boot loader: copies DEPTH bytes from the I2C EEPROM controller into program RAM
// while holding the CPU halted. Optional trailing checksum byte: LOADER_CHECKSUM_EN.
module eeprom_loader
    import computer_pkg::*;
#(
    parameter int                DEPTH   = 16,
    parameter int                ADDR_W  = 4,
    parameter logic [DATA_W-1:0] EE_BASE = EE_BASE_DEFAULT,
    parameter int                TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    output logic              ee_req,
    output logic [DATA_W-1:0] ee_addr,
    input  logic              ee_ack,
    input  logic [DATA_W-1:0] ee_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              hlt,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              csum_err
);

    localparam int                TMO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    loader_state_t     state;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] sum;
    logic              busy_q;
    logic              tmo_clear;
    logic              tmo_load;
    logic              tmo_en;
    logic              tmo_expired;

    assign tmo_clear = go && is_quiescent(state);
    assign tmo_load  = (state == S_REQ) || (state == S_CSUM_REQ);
    assign tmo_en    = ((state == S_WAIT) || (state == S_CSUM_WAIT)) && !ee_ack;

    // Loading TIMEOUT in the request cycle gives TIMEOUT+1 wait cycles before expiry.
    loader_timeout #(
        .W(TMO_W)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmo_clear),
        .load     (tmo_load),
        .load_val (TMO_W'(TIMEOUT)),
        .en       (tmo_en),
        .expired  (tmo_expired)
    );

`ifdef LOADER_CHECKSUM_EN
    logic csum_err_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            sum      <= '0;
            ee_req   <= 1'b0;
            ee_addr  <= '0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
            busy_q   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_err_q <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless a transition below re-asserts them.
            ee_req <= 1'b0;
            ram_we <= 1'b0;

            case (state)
                S_IDLE, S_FIN, S_FAIL: begin
                    if (go) begin
                        done    <= 1'b0;
                        err     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        csum_err_q <= 1'b0;
`endif
                        idx     <= '0;
                        sum     <= '0;
                        ee_req  <= 1'b1;
                        ee_addr <= EE_BASE;
                        busy_q  <= 1'b1;
                        state   <= S_REQ;
                    end
                end

                S_REQ: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (ee_ack) begin
                        ram_we   <= 1'b1;
                        ram_addr <= idx;
                        ram_data <= ee_data;
                        state    <= S_WRITE;
                    end else if (tmo_expired) begin
                        err    <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_FAIL;
                    end
                end

                S_WRITE: begin
                    sum <= sum + ram_data;
                    if (idx == LAST_IDX) begin
`ifdef LOADER_CHECKSUM_EN
                        ee_req  <= 1'b1;
                        ee_addr <= EE_BASE + DATA_W'(DEPTH);
                        state   <= S_CSUM_REQ;
`else
                        done   <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_FIN;
`endif
                    end else begin
                        idx     <= idx + 1'b1;
                        ee_req  <= 1'b1;
                        ee_addr <= EE_BASE + DATA_W'(idx) + 8'd1;
                        state   <= S_REQ;
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                S_CSUM_REQ: begin
                    state <= S_CSUM_WAIT;
                end

                S_CSUM_WAIT: begin
                    if (ee_ack) begin
                        csum_err_q <= (ee_data != sum);
                        done       <= 1'b1;
                        busy_q     <= 1'b0;
                        state      <= S_FIN;
                    end else if (tmo_expired) begin
                        err    <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_FAIL;
                    end
                end
`endif

                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign hlt  = busy_q;

`ifdef LOADER_CHECKSUM_EN
    assign csum_err = csum_err_q;
`else
    assign csum_err = 1'b0;
`endif

endmodule

// File: tb/tb_eeprom_loader.sv
// Directed bench for eeprom_loader: an EEPROM responder model feeds a write
// scoreboard, and RAM contents, handshake counts and timing are compared against it.
module tb_eeprom_loader;
    import computer_pkg::*;

    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 1023;
`ifdef LOADER_CHECKSUM_EN
    localparam int N_REQ = DEPTH + 1;
`else
    localparam int N_REQ = DEPTH;
`endif

    logic              clk     = 1'b0;
    logic              reset   = 1'b0;
    logic              go      = 1'b0;
    logic              ee_ack  = 1'b0;
    logic [7:0]        ee_data = 8'h00;
    logic              ee_req;
    logic [7:0]        ee_addr;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic              hlt;
    logic              busy;
    logic              done;
    logic              err;
    logic              csum_err;

    eeprom_loader #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .EE_BASE (8'h00),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .ee_req   (ee_req),
        .ee_addr  (ee_addr),
        .ee_ack   (ee_ack),
        .ee_data  (ee_data),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .hlt      (hlt),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .csum_err (csum_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] eeprom [0:255];
    logic [7:0] ram_model [0:DEPTH-1];
    bit         ram_written [0:DEPTH-1];

    int n_checks = 0;
    int n_errors = 0;
    int req_count, we_count, done_cyc, err_cyc, hang_req_cyc, hlt_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_ram();
        for (int i = 0; i < DEPTH; i++) begin
            ram_model[i]   = 8'h00;
            ram_written[i] = 1'b0;
        end
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("%s_written_%0d", tag, i), 32'(ram_written[i]), 32'd1);
            check($sformatf("%s_ram_%0d", tag, i), 32'(ram_model[i]), 32'(eeprom[i]));
        end
    endtask

    // Pulses GO and then, once per cycle at the falling edge, answers requests,
    // scores RAM writes and watches HLT/BUSY until DONE or ERR rises.
    // Sample cyc reflects the state after edge GO+cyc-1.
    task automatic run_load(input int dmin, input int dmax, input int hang_idx,
                            input bit abort, input bit noise);
        int  countdown = 0;
        int  cur_idx   = 0;
        bit  pending   = 1'b0;
        wr_t w;
        exp_q.delete();
        req_count = 0; we_count = 0; done_cyc = -1; err_cyc = -1;
        hang_req_cyc = -1; hlt_bad = 0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            ee_ack = 1'b0;
            go     = 1'b0;
            if (ee_req === 1'b1) begin
                check("ee_addr", 32'(ee_addr), 32'(req_count));
                cur_idx = req_count;
                req_count++;
                pending = 1'b1;
                if (cur_idx == hang_idx) begin
                    countdown    = -1;
                    hang_req_cyc = cyc;
                end else begin
                    countdown = int'($urandom_range(dmax, dmin));
                end
                if (noise) begin
                    ee_ack  = 1'b1;
                    ee_data = 8'hEE;
                    if (cur_idx == 8) go = 1'b1;
                end
            end else if (pending && countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    ee_ack  = 1'b1;
                    ee_data = eeprom[cur_idx];
                    pending = 1'b0;
                    if (cur_idx < DEPTH) exp_q.push_back('{addr: ADDR_W'(cur_idx), data: eeprom[cur_idx]});
                end
            end
            if (ram_we === 1'b1) begin
                we_count++;
                if (exp_q.size() == 0) begin
                    check("ram_we_stray", 32'(ram_we), 32'd0);
                end else begin
                    w = exp_q.pop_front();
                    check("ram_addr", 32'(ram_addr), 32'(w.addr));
                    check("ram_data", 32'(ram_data), 32'(w.data));
                    ram_model[ram_addr]   = ram_data;
                    ram_written[ram_addr] = 1'b1;
                end
            end
            if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (err === 1'b1 && err_cyc < 0) err_cyc = cyc;
            if (done_cyc < 0 && err_cyc < 0 && (hlt !== 1'b1 || busy !== 1'b1)) hlt_bad++;
            if (done_cyc >= 0 || err_cyc >= 0) break;
            if (abort && hang_req_cyc >= 0 && cyc == hang_req_cyc + 3) return;
            @(negedge clk);
        end
        check("load_terminated", 32'(done_cyc >= 0 || err_cyc >= 0), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) eeprom[i] = 8'h00;
        clear_ram();

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ee_req", 32'(ee_req), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_hlt", 32'(hlt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_csum_err", 32'(csum_err), 32'd0);
        check("rst_state", 32'(dut.state), 32'(S_IDLE));
        reset = 1'b1;
        @(negedge clk);

        // Back-to-back ACKs: 3 cycles per byte, DONE rises at edge GO+48
        for (int i = 0; i < DEPTH; i++) eeprom[i] = 8'(8'hA0 + i);
        clear_ram();
        run_load(1, 1, -1, 1'b0, 1'b0);
        check_ram("t1");
        check("t1_req_count", 32'(req_count), 32'(N_REQ));
        check("t1_done", 32'(done), 32'd1);
        check("t1_err", 32'(err), 32'd0);
        check("t1_hlt_after", 32'(hlt), 32'd0);
        check("t1_hlt_during", 32'(hlt_bad), 32'd0);
`ifndef LOADER_CHECKSUM_EN
        check("t1_done_edge", 32'(done_cyc - 1), 32'd48);
        check("t1_csum_err", 32'(csum_err), 32'd0);
`endif

        // Random ACK delays 1..20
        for (int i = 0; i < DEPTH; i++) eeprom[i] = 8'(~i);
        clear_ram();
        run_load(1, 20, -1, 1'b0, 1'b0);
        check_ram("t2");
        check("t2_req_count", 32'(req_count), 32'(N_REQ));
        check("t2_we_count", 32'(we_count), 32'(DEPTH));
        check("t2_done", 32'(done), 32'd1);
        check("t2_hlt_during", 32'(hlt_bad), 32'd0);

        // ACK withheld on byte 5: REQ plus TIMEOUT+1 WAIT cycles, then ERR
        for (int i = 0; i < DEPTH; i++) eeprom[i] = 8'(8'h50 + i);
        clear_ram();
        run_load(1, 1, 5, 1'b0, 1'b0);
        check("t3_err", 32'(err), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        check("t3_hlt", 32'(hlt), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_timeout_len", 32'(err_cyc - hang_req_cyc), 32'(TIMEOUT + 2));
        check("t3_req_count", 32'(req_count), 32'd6);
        for (int i = 0; i < DEPTH; i++)
            check($sformatf("t3_written_%0d", i), 32'(ram_written[i]), (i < 5) ? 32'd1 : 32'd0);
        for (int i = 0; i < DEPTH; i++) eeprom[i] = 8'(8'h60 + i);
        clear_ram();
        run_load(1, 1, -1, 1'b0, 1'b0);
        check_ram("t3r");
        check("t3r_err", 32'(err), 32'd0);
        check("t3r_done", 32'(done), 32'd1);

        // Asynchronous reset during the WAIT of byte 7
        for (int i = 0; i < DEPTH; i++) eeprom[i] = 8'(8'h70 + i);
        clear_ram();
        run_load(1, 1, 7, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("t4_ee_req", 32'(ee_req), 32'd0);
        check("t4_ee_addr", 32'(ee_addr), 32'd0);
        check("t4_ram_we", 32'(ram_we), 32'd0);
        check("t4_ram_addr", 32'(ram_addr), 32'd0);
        check("t4_ram_data", 32'(ram_data), 32'd0);
        check("t4_hlt", 32'(hlt), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_done", 32'(done), 32'd0);
        check("t4_err", 32'(err), 32'd0);
        check("t4_csum_err", 32'(csum_err), 32'd0);
        check("t4_state", 32'(dut.state), 32'(S_IDLE));
        check("t4_idx", 32'(dut.idx), 32'd0);
        check("t4_partial_6", 32'(ram_written[6]), 32'd1);
        check("t4_partial_7", 32'(ram_written[7]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clear_ram();
        run_load(1, 1, -1, 1'b0, 1'b0);
        check_ram("t4r");
        check("t4r_done", 32'(done), 32'd1);

        // Spurious ACK in every REQ and a GO pulse mid-load are ignored
        for (int i = 0; i < DEPTH; i++) eeprom[i] = 8'(8'h80 ^ (i * 7));
        clear_ram();
        run_load(1, 1, -1, 1'b0, 1'b1);
        check_ram("t5");
        check("t5_we_count", 32'(we_count), 32'(DEPTH));
        check("t5_req_count", 32'(req_count), 32'(N_REQ));
        check("t5_done", 32'(done), 32'd1);
`ifndef LOADER_CHECKSUM_EN
        check("t5_done_edge", 32'(done_cyc - 1), 32'd48);
        check("t5_csum_err", 32'(csum_err), 32'd0);
`endif

`ifdef LOADER_CHECKSUM_EN
        // Checksum byte at EE_BASE+DEPTH: sixteen 0x01 bytes sum to 0x10
        for (int i = 0; i < DEPTH; i++) eeprom[i] = 8'h01;
        eeprom[DEPTH] = 8'h10;
        clear_ram();
        run_load(1, 3, -1, 1'b0, 1'b0);
        check("t6_csum_err_ok", 32'(csum_err), 32'd0);
        check("t6_done_ok", 32'(done), 32'd1);
        check("t6_req_count", 32'(req_count), 32'(N_REQ));
        eeprom[DEPTH] = 8'h11;
        clear_ram();
        run_load(1, 3, -1, 1'b0, 1'b0);
        check("t6_csum_err_bad", 32'(csum_err), 32'd1);
        check("t6_done_bad", 32'(done), 32'd1);
        check("t6_err_bad", 32'(err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
